// File: rtl/risc_register_file.sv
// Integer register file: two read ports (A=rs1, B=rs2), one write port, x0 hardwired to zero.
// Latency: request accepted at edge k, data/ack valid in the cycle after edge k; write commits at edge k.
// Backpressure: each port's two-state IDLE/ACK FSM ignores valid while in ACK, so a held valid acks every second cycle.
// Optional feature: define REG_FILE_BYPASS_EN to forward a same-edge write to the read ports.
module risc_register_file #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr_a,
    input  logic                  reg_rd_addrs_a_valid,
    output logic [DATA_WIDTH-1:0] reg_rd_data_a,
    output logic                  reg_rd_data_a_ack,
    input  logic [ADDR_WIDTH-1:0] reg_rd_addr_b,
    input  logic                  reg_rd_addrs_b_valid,
    output logic [DATA_WIDTH-1:0] reg_rd_data_b,
    output logic                  reg_rd_data_b_ack,
    input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_wr_valid,
    output logic                  reg_wr_ack
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } port_state_t;

    port_state_t           rd_a_state_q, rd_a_state_d;
    port_state_t           rd_b_state_q, rd_b_state_d;
    port_state_t           wr_state_q,   wr_state_d;

    logic                  rd_a_ack_q, rd_a_ack_d;
    logic                  rd_b_ack_q, rd_b_ack_d;
    logic                  wr_ack_q,   wr_ack_d;

    logic [DATA_WIDTH-1:0] rd_a_data_q, rd_a_data_d;
    logic [DATA_WIDTH-1:0] rd_b_data_q, rd_b_data_d;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  rd_a_accept;
    logic                  rd_b_accept;
    logic                  wr_accept;
    logic                  rd_a_live;
    logic                  rd_b_live;
    logic                  wr_live;

    // A port accepts only from IDLE; an address is "live" when nonzero and inside the array.
    always_comb begin
        rd_a_accept = (rd_a_state_q == ST_IDLE) && reg_rd_addrs_a_valid;
        rd_b_accept = (rd_b_state_q == ST_IDLE) && reg_rd_addrs_b_valid;
        wr_accept   = (wr_state_q   == ST_IDLE) && reg_wr_valid;
        rd_a_live   = (reg_rd_addr_a != '0) && (int'(reg_rd_addr_a) < NUM_REGS);
        rd_b_live   = (reg_rd_addr_b != '0) && (int'(reg_rd_addr_b) < NUM_REGS);
        wr_live     = (reg_wr_addr   != '0) && (int'(reg_wr_addr)   < NUM_REGS);
    end

    // Next-state for the three handshake FSMs: IDLE->ACK on accept, ACK->IDLE unconditionally.
    always_comb begin
        rd_a_state_d = rd_a_accept ? ST_ACK : ST_IDLE;
        rd_b_state_d = rd_b_accept ? ST_ACK : ST_IDLE;
        wr_state_d   = wr_accept   ? ST_ACK : ST_IDLE;
        rd_a_ack_d   = rd_a_accept;
        rd_b_ack_d   = rd_b_accept;
        wr_ack_d     = wr_accept;
    end

    // Read data capture; dead addresses return zero and the output holds between acceptances.
    always_comb begin
        rd_a_data_d = rd_a_data_q;
        rd_b_data_d = rd_b_data_q;
        if (rd_a_accept) begin
            rd_a_data_d = '0;
            if (rd_a_live) begin
                rd_a_data_d = regs_q[reg_rd_addr_a];
`ifdef REG_FILE_BYPASS_EN
                if (wr_accept && (reg_wr_addr == reg_rd_addr_a)) begin
                    rd_a_data_d = reg_wr_data;
                end
`endif
            end
        end
        if (rd_b_accept) begin
            rd_b_data_d = '0;
            if (rd_b_live) begin
                rd_b_data_d = regs_q[reg_rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
                if (wr_accept && (reg_wr_addr == reg_rd_addr_b)) begin
                    rd_b_data_d = reg_wr_data;
                end
`endif
            end
        end
    end

    // Array update: writes to x0 or past the end are acked but dropped.
    always_comb begin
        regs_d = regs_q;
        if (wr_accept && wr_live) begin
            regs_d[reg_wr_addr] = reg_wr_data;
        end
    end

    // State, registered outputs and array; reset clears everything including pending acks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_state_q <= ST_IDLE;
            rd_b_state_q <= ST_IDLE;
            wr_state_q   <= ST_IDLE;
            rd_a_ack_q   <= 1'b0;
            rd_b_ack_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_a_data_q  <= '0;
            rd_b_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            rd_a_state_q <= rd_a_state_d;
            rd_b_state_q <= rd_b_state_d;
            wr_state_q   <= wr_state_d;
            rd_a_ack_q   <= rd_a_ack_d;
            rd_b_ack_q   <= rd_b_ack_d;
            wr_ack_q     <= wr_ack_d;
            rd_a_data_q  <= rd_a_data_d;
            rd_b_data_q  <= rd_b_data_d;
            regs_q       <= regs_d;
        end
    end

    assign reg_rd_data_a     = rd_a_data_q;
    assign reg_rd_data_a_ack = rd_a_ack_q;
    assign reg_rd_data_b     = rd_b_data_q;
    assign reg_rd_data_b_ack = rd_b_ack_q;
    assign reg_wr_ack        = wr_ack_q;

endmodule

// File: doc/risc_register_file.md
# risc_register_file

Integer register file that answers the register read requests issued by the instruction handler and accepts result writes from the ALU write-back path. Provides two independent read ports (A = rs1, B = rs2) and one write port. Every port uses a valid/ack handshake with a one-cycle-pulse ack. Register x0 is hardwired to zero.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; index 0 reads as zero.
- ADDR_WIDTH, 5, register index width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- DATA_WIDTH, 32, register width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- reg_rd_addr_a  input  ADDR_WIDTH  port A read index.
- reg_rd_addrs_a_valid  input  1  port A request valid.
- reg_rd_data_a  output  DATA_WIDTH  port A read data.
- reg_rd_data_a_ack  output  1  port A ack; one-cycle pulse.
- reg_rd_addr_b, reg_rd_addrs_b_valid, reg_rd_data_b, reg_rd_data_b_ack: same as port A, for port B.
- reg_wr_addr  input  ADDR_WIDTH  write index.
- reg_wr_data  input  DATA_WIDTH  write data.
- reg_wr_valid  input  1  write request valid.
- reg_wr_ack  output  1  write ack; one-cycle pulse.

## Operation
- Each of the three ports has an independent two-state FSM: IDLE and ACK.
- IDLE -> ACK when valid is sampled high at a rising edge. This is the acceptance edge.
- ACK -> IDLE unconditionally on the next edge. Valid sampled in ACK is ignored.
- Read acceptance:
  - reg_rd_data_x is loaded with the register at the sampled address.
  - Address 0 always returns 0.
  - An address >= NUM_REGS returns 0.
- Write acceptance:
  - The register is updated at the acceptance edge.
  - Writes to address 0 or to an address >= NUM_REGS are acked but have no effect.
- Ack is high only while the FSM is in ACK.
- reg_rd_data_x holds its value until the next read acceptance on that port.
- Ports A and B may read the same address in the same cycle; both return identical data.
- Read/write ordering: a write accepted at an earlier edge is always visible to later reads.
- Same-edge read and write to the same nonzero address: the result depends on the configuration macro (see Configuration).
- Reset values: all registers 0, reg_rd_data_a/b = 0, all acks 0, all FSMs IDLE.
- Reset asserted mid-handshake:
  - Any pending ack is dropped immediately (asynchronously).
  - Any write accepted before reset is lost, because the array clears.

## Timing
- Read latency: valid sampled at edge k; data and ack are valid in the cycle after edge k; ack falls at edge k+1.
- Earliest next acceptance on the same port: edge k+2. A continuously held valid therefore produces an ack every second cycle.
- Write latency: array updated at edge k; reg_wr_ack is high in the cycle after edge k.
- Read and write ports never stall each other. All three ports can accept at the same edge.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- REG_FILE_BYPASS_EN defined: on a read and a write accepted at the same edge to the same nonzero address, the read returns reg_wr_data (write-to-read forwarding). Forwarding applies independently to both read ports.
- REG_FILE_BYPASS_EN undefined: the same-edge read returns the value held before the write. The write still commits at that edge.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset: assert reset asynchronously between edges -> reg_rd_data_a/b = 0 and all acks 0 immediately; reads of x1..x31 after release return 0.
- Write x5 = 0xDEADBEEF, then read port A addr 5 -> reg_wr_ack pulses 1 cycle; in the cycle after the read acceptance, reg_rd_data_a = 0xDEADBEEF with a 1-cycle ack.
- Write x0 = 0x12345678, then read port A and port B addr 0 in the same cycle -> write is acked; both ports return 0x00000000 with simultaneous acks.
- Hold reg_rd_addrs_b_valid high for 6 cycles, addr 7 = 0x0000_00AA -> 3 ack pulses on alternate cycles, each with data 0xAA.
- x9 = 0x11111111, then the same edge accepts a write of x9 = 0x22222222 and a port A read of x9 -> returns 0x22222222 with REG_FILE_BYPASS_EN, 0x11111111 without; a read at the next acceptance returns 0x22222222 in both builds.
- Accept a read on port A, then assert reset during its ack cycle -> ack drops immediately; after release, the port accepts a new request on the first edge with valid high.
